// File: rtl/iterative_multiplier_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package iterative_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int iter_of(input int width_b, input int bits_per_cycle);
        return width_b / bits_per_cycle;
    endfunction

    // Counter must hold 0..ITER-1; keep at least one bit for the single-iteration case.
    function automatic int cnt_width(input int iter);
        return (iter <= 1) ? 1 : $clog2(iter);
    endfunction

    localparam int ITER_DEFAULT = iter_of(4, 1);

endpackage

// File: rtl/iterative_multiplier_pp_row.sv
// One partial-product row: adds (mcand AND mbit) << SHIFT onto the running sum.
module mul_pp_row #(
    parameter int PW    = 8,
    parameter int SHIFT = 0
) (
    input  logic [PW-1:0] mcand,
    input  logic          mbit,
    input  logic [PW-1:0] acc_in,
    output logic [PW-1:0] acc_out
);

    logic [PW-1:0] pp;

    assign pp      = (mcand & {PW{mbit}}) << SHIFT;
    assign acc_out = acc_in + pp;

endmodule

// File: rtl/iterative_multiplier.sv
// Sequential shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Optional signed operands when SIGNED_MODE_EN is defined.
module iterative_multiplier
    import iterative_multiplier_pkg::*;
#(
    parameter int WIDTH_A        = 4,
    parameter int WIDTH_B        = 4,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
`ifdef SIGNED_MODE_EN
    input  logic                       op_signed,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product
);

    localparam int PW   = WIDTH_A + WIDTH_B;
    localparam int ITER = iter_of(WIDTH_B, BITS_PER_CYCLE);
    localparam int CW   = cnt_width(ITER);

    if (WIDTH_A < 2 || WIDTH_B < 2 || BITS_PER_CYCLE < 1 ||
        (WIDTH_B % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("iterative_multiplier: BITS_PER_CYCLE must divide WIDTH_B, widths >= 2");
    end

    state_t              state;
    logic [PW-1:0]       mcand;
    logic [WIDTH_B-1:0]  mplier;
    logic [PW-1:0]       acc;
    logic [CW-1:0]       cnt;
    logic [WIDTH_A-1:0]  a_mag;
    logic [WIDTH_B-1:0]  b_mag;
    logic                neg_in;
    logic                neg;
    logic [BITS_PER_CYCLE:0][PW-1:0] chain;
    logic [PW-1:0]       final_sum;

`ifdef SIGNED_MODE_EN
    logic a_neg;
    logic b_neg;
    assign a_neg  = op_signed & a[WIDTH_A-1];
    assign b_neg  = op_signed & b[WIDTH_B-1];
    // Negating the most-negative value wraps to itself, which is its correct unsigned magnitude.
    assign a_mag  = a_neg ? (~a + WIDTH_A'(1)) : a;
    assign b_mag  = b_neg ? (~b + WIDTH_B'(1)) : b;
    assign neg_in = a_neg ^ b_neg;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign neg_in = 1'b0;
`endif

    assign chain[0] = acc;

    for (genvar j = 0; j < BITS_PER_CYCLE; j++) begin : g_row
        mul_pp_row #(
            .PW   (PW),
            .SHIFT(j)
        ) u_row (
            .mcand  (mcand),
            .mbit   (mplier[j]),
            .acc_in (chain[j]),
            .acc_out(chain[j+1])
        );
    end

    assign final_sum = chain[BITS_PER_CYCLE];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= PW'(a_mag);
                        mplier   <= b_mag;
                        neg      <= neg_in;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= final_sum;
                    mcand  <= mcand << BITS_PER_CYCLE;
                    mplier <= mplier >> BITS_PER_CYCLE;
                    if (cnt == CW'(ITER - 1)) begin
                        product   <= neg ? (~final_sum + PW'(1)) : final_sum;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
